// File: rtl/ahb_cmd_queue.sv
// Command queue/issuer feeding the AHB master: buffers {OPCODE, DATA} pairs and
// issues them one at a time with an idle cycle between. Optional watchdog: CMDQ_TIMEOUT_EN.
module ahb_cmd_queue #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [31:0]            IN_OPCODE,
  input  logic [31:0]            IN_DATA,
  output logic [31:0]            OPCODE,
  output logic [31:0]            DATA,
  input  logic                   WAIT,
  input  logic                   DONE,
  output logic                   BUSY,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   ERR,
  output logic [1:0]             dbg_state
);

  // Push handshake: a transfer happens at a rising edge where IN_VALID && IN_READY.
  // IN_READY looks only at the registered count, never at a same-cycle pop, and
  // IN_VALID may rise or fall freely; a zero opcode is accepted and then dropped.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t        state;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          tmo_abort;

  assign IN_READY  = !HRESET && (count != FULL);
  assign push      = IN_VALID && IN_READY && (IN_OPCODE != 32'd0);
  assign pop       = (state == S_ACTIVE) && (DONE || tmo_abort);
  assign COUNT     = count;
  assign dbg_state = state;

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= {IN_OPCODE, IN_DATA};
    end
  end

  // The head entry stays queued while it is outstanding and leaves on pop.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= S_IDLE;
      OPCODE <= '0;
      DATA   <= '0;
      BUSY   <= 1'b0;
    end else begin
      case (state)
        // GAP only differs from IDLE in guaranteeing one zero cycle after a pop.
        S_IDLE, S_GAP: begin
          if (count != '0) begin
            {OPCODE, DATA} <= mem[rd_ptr];
            BUSY           <= 1'b1;
            state          <= S_ACTIVE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACTIVE: begin
          if (pop) begin
            OPCODE <= '0;
            DATA   <= '0;
            BUSY   <= 1'b0;
            state  <= S_GAP;
          end
        end
        default: begin
          OPCODE <= '0;
          DATA   <= '0;
          BUSY   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CMDQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] tmo_cnt;

  // Counter is held at zero outside ACTIVE, so it starts from zero on entry.
  assign tmo_abort = (state == S_ACTIVE) && (tmo_cnt == TMO_LAST) && !DONE;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tmo_cnt <= '0;
      ERR     <= 1'b0;
    end else begin
      ERR <= tmo_abort;
      if (state != S_ACTIVE) begin
        tmo_cnt <= '0;
      end else if (!WAIT) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end
`else
  logic        unused_wait;
  logic [15:0] unused_timeout;

  assign tmo_abort      = 1'b0;
  assign ERR            = 1'b0;
  assign unused_wait    = WAIT;
  assign unused_timeout = 16'(TIMEOUT);
`endif

endmodule

// File: tb/tb_ahb_cmd_queue.sv
// Bench for ahb_cmd_queue: a fixed vector table, directed corner sequences, and
// random traffic checked against a queue-based reference model.
module tb_ahb_cmd_queue;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;
  localparam int CW    = 4;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [31:0]   IN_OPCODE = '0;
  logic [31:0]   IN_DATA = '0;
  logic [31:0]   OPCODE;
  logic [31:0]   DATA;
  logic          WAIT = 1'b0;
  logic          DONE = 1'b0;
  logic          BUSY;
  logic [CW-1:0] COUNT;
  logic          ERR;
  logic [1:0]    dbg_state;

  ahb_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OPCODE(IN_OPCODE), .IN_DATA(IN_DATA), .OPCODE(OPCODE), .DATA(DATA),
    .WAIT(WAIT), .DONE(DONE), .BUSY(BUSY), .COUNT(COUNT), .ERR(ERR),
    .dbg_state(dbg_state)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: queued commands (head is the outstanding one when issued).
  logic [63:0] exp_q[$];
  bit          m_issued;
  logic [31:0] m_op;
  logic [31:0] m_data;
  int          m_tmo;
  bit          m_err;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] op;
    logic [31:0] d;
    logic        dn;
    logic        wt;
    logic [31:0] e_op;
    logic [31:0] e_d;
    logic [3:0]  e_cnt;
    logic        e_busy;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance model, step DUT, compare everything.
  task automatic cycle(input bit v, input logic [31:0] op, input logic [31:0] d,
                       input bit dn, input bit wt, input bit rst);
    bit rdy;
    bit tmo;
    IN_VALID  = v;
    IN_OPCODE = op;
    IN_DATA   = d;
    DONE      = dn;
    WAIT      = wt;
    HRESET    = rst;
    #1;
    rdy = !rst && (exp_q.size() < DEPTH);
    check("in_ready", {63'd0, IN_READY}, {63'd0, rdy});
    tmo = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_issued = 1'b0;
      m_op     = '0;
      m_data   = '0;
      m_tmo    = 0;
      m_err    = 1'b0;
    end else begin
`ifdef CMDQ_TIMEOUT_EN
      tmo = m_issued && (m_tmo == TMO - 1);
`endif
      m_err = tmo && !dn;
      if (m_issued && (dn || tmo)) begin
        m_issued = 1'b0;
        m_op     = '0;
        m_data   = '0;
        void'(exp_q.pop_front());
      end else if (m_issued) begin
        if (!wt) m_tmo++;
      end else if (exp_q.size() != 0) begin
        m_issued       = 1'b1;
        {m_op, m_data} = exp_q[0];
        m_tmo          = 0;
      end
      if (v && rdy && op != 32'd0) exp_q.push_back({op, d});
    end
    @(posedge HCLK);
    #1;
    check("opcode", {32'd0, OPCODE}, {32'd0, m_op});
    check("data", {32'd0, DATA}, {32'd0, m_data});
    check("busy", {63'd0, BUSY}, {63'd0, m_issued});
    check("count", {60'd0, COUNT}, 64'(exp_q.size()));
    check("err", {63'd0, ERR}, {63'd0, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int k;
    bit pv;

    // rst, v, op, d, done, wait | opcode, data, count, busy, ready
    tbl[0]  = '{1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'd0, 0, 0};
    tbl[1]  = '{0, 1, 32'h1, 32'hAAAA0000, 0, 0, 32'h0, 32'h0, 4'd1, 0, 1};
    tbl[2]  = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h1, 32'hAAAA0000, 4'd1, 1, 1};
    tbl[3]  = '{0, 1, 32'h2, 32'hBBBB0001, 0, 0, 32'h1, 32'hAAAA0000, 4'd2, 1, 1};
    tbl[4]  = '{0, 1, 32'h3, 32'hCCCC0002, 0, 0, 32'h1, 32'hAAAA0000, 4'd3, 1, 1};
    tbl[5]  = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h1, 32'hAAAA0000, 4'd3, 1, 1};
    tbl[6]  = '{0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 4'd2, 0, 1};
    tbl[7]  = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h2, 32'hBBBB0001, 4'd2, 1, 1};
    tbl[8]  = '{0, 0, 32'h0, 32'h0, 0, 1, 32'h2, 32'hBBBB0001, 4'd2, 1, 1};
    tbl[9]  = '{0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 4'd1, 0, 1};
    tbl[10] = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h3, 32'hCCCC0002, 4'd1, 1, 1};
    tbl[11] = '{0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 4'd0, 0, 1};
    tbl[12] = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'd0, 0, 1};
    tbl[13] = '{0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 4'd0, 0, 1};
    tbl[14] = '{0, 1, 32'h0, 32'hDEAD, 0, 0, 32'h0, 32'h0, 4'd0, 0, 1};
    tbl[15] = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'd0, 0, 1};

    @(posedge HCLK);
    #1;
    for (int i = 0; i < 16; i++) begin
      HRESET    = tbl[i].rst;
      IN_VALID  = tbl[i].v;
      IN_OPCODE = tbl[i].op;
      IN_DATA   = tbl[i].d;
      DONE      = tbl[i].dn;
      WAIT      = tbl[i].wt;
      @(posedge HCLK);
      #1;
      check($sformatf("tbl%0d_opcode", i), {32'd0, OPCODE}, {32'd0, tbl[i].e_op});
      check($sformatf("tbl%0d_data", i), {32'd0, DATA}, {32'd0, tbl[i].e_d});
      check($sformatf("tbl%0d_count", i), {60'd0, COUNT}, {60'd0, tbl[i].e_cnt});
      check($sformatf("tbl%0d_busy", i), {63'd0, BUSY}, {63'd0, tbl[i].e_busy});
      check($sformatf("tbl%0d_ready", i), {63'd0, IN_READY}, {63'd0, tbl[i].e_rdy});
      check($sformatf("tbl%0d_err", i), {63'd0, ERR}, 64'd0);
    end

    // Fill to DEPTH, then a push racing a pop must be refused.
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h10 + 32'(i), 32'h5000 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("full_count", {60'd0, COUNT}, 64'd8);
    check("full_ready", {63'd0, IN_READY}, 64'd0);
    cycle(1'b1, 32'h99, 32'h9999, 1'b1, 1'b0, 1'b0);
    check("refused_count", {60'd0, COUNT}, 64'd7);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("ready_after_pop", {63'd0, IN_READY}, 64'd1);
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'd0, 32'd0, (i % 3) == 1, 1'b0, 1'b0);
    check("drained_count", {60'd0, COUNT}, 64'd0);

    // 20 commands through the ring to exercise pointer wrap and ordering.
    k = 0;
    for (int c = 0; c < 150; c++) begin
      pv = (k < 20) && (exp_q.size() < DEPTH);
      cycle(k < 20, 32'h100 + 32'(k), 32'hA000 + 32'(k), (c % 3) == 2, 1'b0, 1'b0);
      if (pv) k++;
    end
    check("wrap_pushed", 64'(k), 64'd20);
    check("wrap_idle_count", {60'd0, COUNT}, 64'd0);

    // Long WAIT stall: command must stay put, no abort while stalled.
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h42, 32'h12345678, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 50; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("wait_opcode_held", {32'd0, OPCODE}, 64'h42);
    check("wait_data_held", {32'd0, DATA}, 64'h12345678);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    check("wait_done_opcode", {32'd0, OPCODE}, 64'd0);

    // Reset in the middle of an outstanding command.
    cycle(1'b1, 32'h7, 32'h77, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h8, 32'h88, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("pre_reset_busy", {63'd0, BUSY}, 64'd1);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("reset_opcode", {32'd0, OPCODE}, 64'd0);
    check("reset_count", {60'd0, COUNT}, 64'd0);
    idle(3);

`ifdef CMDQ_TIMEOUT_EN
    // No DONE: abort with ERR after TMO unstalled ACTIVE cycles.
    cycle(1'b1, 32'h55, 32'h5555, 1'b0, 1'b0, 1'b0);
    idle(1);
    idle(TMO - 1);
    check("tmo_before_err", {63'd0, ERR}, 64'd0);
    idle(1);
    check("tmo_err", {63'd0, ERR}, 64'd1);
    check("tmo_popped", {60'd0, COUNT}, 64'd0);
    idle(2);
    // DONE on the final cycle beats the abort.
    cycle(1'b1, 32'h66, 32'h6666, 1'b0, 1'b0, 1'b0);
    idle(1);
    idle(TMO - 1);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("tmo_done_wins", {63'd0, ERR}, 64'd0);
    idle(2);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      cycle($urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
            $urandom,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
